// File: rtl/bfu_pkg.sv
// Shared butterfly constants and types used by the forward/inverse butterflies
// and the twiddle ROM.
package bfu_pkg;

  localparam int W_DEF    = 32;
  localparam int FRAC_DEF = 16;

  // 1.0 in the default Q(W_DEF-FRAC_DEF).FRAC_DEF format.
  localparam logic [W_DEF-1:0] ONE = W_DEF'(1) << FRAC_DEF;

  typedef struct packed {
    logic [W_DEF-1:0] re;
    logic [W_DEF-1:0] im;
  } cplx_t;

endpackage

// File: rtl/cmult_conj_pipe.sv
// Two-stage complex multiplier computing x * conj(w) in fixed point, with a
// strobe flagging a combine-stage result that does not fit in W signed bits.
module cmult_conj_pipe
  import bfu_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] x_r_i,
  input  logic [W-1:0] x_i_i,
  input  logic [W-1:0] w_r_i,
  input  logic [W-1:0] w_i_i,
  output logic [W-1:0] y_r_o,
  output logic [W-1:0] y_i_o,
  output logic         ovf_o
);

  logic [2*W-1:0] xr_ext, xi_ext, wr_ext, wi_ext;
  logic [2*W-1:0] pr0_d, pr1_d, pi0_d, pi1_d;
  logic [2*W-1:0] pr0_q, pr1_q, pi0_q, pi1_q;

  logic signed [2*W:0] yr_sum, yi_dif, yr_sh, yi_sh;
  logic                fit_r, fit_i;

  // Sign-extend to the full product width so the low 2W bits are the exact product.
  assign xr_ext = {{W{x_r_i[W-1]}}, x_r_i};
  assign xi_ext = {{W{x_i_i[W-1]}}, x_i_i};
  assign wr_ext = {{W{w_r_i[W-1]}}, w_r_i};
  assign wi_ext = {{W{w_i_i[W-1]}}, w_i_i};

  assign pr0_d = xr_ext * wr_ext;
  assign pr1_d = xi_ext * wi_ext;
  assign pi0_d = xi_ext * wr_ext;
  assign pi1_d = xr_ext * wi_ext;

  // NOTE: pure datapath registers carry no reset; the valid pipeline in the
  // parent decides whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (en_i) begin
      pr0_q <= pr0_d;
      pr1_q <= pr1_d;
      pi0_q <= pi0_d;
      pi1_q <= pi1_d;
    end
  end

  // conj(w) flips the sign of the cross terms: re adds, im subtracts.
  assign yr_sum = {pr0_q[2*W-1], pr0_q} + {pr1_q[2*W-1], pr1_q};
  assign yi_dif = {pi0_q[2*W-1], pi0_q} - {pi1_q[2*W-1], pi1_q};
  assign yr_sh  = yr_sum >>> FRAC;
  assign yi_sh  = yi_dif >>> FRAC;

  assign fit_r = ~|yr_sh[2*W:W-1] | &yr_sh[2*W:W-1];
  assign fit_i = ~|yi_sh[2*W:W-1] | &yi_sh[2*W:W-1];
  assign ovf_o = ~fit_r | ~fit_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      y_r_o <= '0;
      y_i_o <= '0;
    end else if (en_i) begin
      y_r_o <= yr_sh[W-1:0];
      y_i_o <= yi_sh[W-1:0];
    end
  end

endmodule

// File: rtl/ibfu_pipe.sv
// Pipelined radix-2 Gentleman-Sande inverse butterfly: A = a + b,
// B = (a - b) * conj(W), 3-cycle latency, valid/ready stream, sticky overflow.
module ibfu_pipe
  import bfu_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int SCALE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_r_in,
  input  logic [W-1:0] a_i_in,
  input  logic [W-1:0] b_r_in,
  input  logic [W-1:0] b_i_in,
  input  logic [W-1:0] tw_r,
  input  logic [W-1:0] tw_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] a_r_out,
  output logic [W-1:0] a_i_out,
  output logic [W-1:0] b_r_out,
  output logic [W-1:0] b_i_out,
  output logic         ovf
);

  logic         adv;
  logic [W:0]   sum_r, sum_i, dif_r, dif_i;
  logic [W-1:0] s_r_d, s_i_d, d_r_d, d_i_d;
  logic         s1_ovf;

  logic [W-1:0] s1_r_q, s1_i_q, d1_r_q, d1_i_q, tw1_r_q, tw1_i_q;
  logic [W-1:0] s2_r_q, s2_i_q;
  logic [W-1:0] a_r_q, a_i_q;
  logic         v1_q, v2_q, v3_q;
  logic         ovf_d, ovf_q;
  logic         cm_ovf;

  // The whole pipe stalls as one unit whenever the output register is full and blocked.
  assign adv      = ~v3_q | out_ready;
  assign in_ready = adv;

  assign sum_r = {a_r_in[W-1], a_r_in} + {b_r_in[W-1], b_r_in};
  assign sum_i = {a_i_in[W-1], a_i_in} + {b_i_in[W-1], b_i_in};
  assign dif_r = {a_r_in[W-1], a_r_in} - {b_r_in[W-1], b_r_in};
  assign dif_i = {a_i_in[W-1], a_i_in} - {b_i_in[W-1], b_i_in};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    s_r_d  = sum_r[W-1:0];
    s_i_d  = sum_i[W-1:0];
    d_r_d  = dif_r[W-1:0];
    d_i_d  = dif_i[W-1:0];
    s1_ovf = 1'b0;
    if (SCALE != 0) begin
      s_r_d = sum_r[W:1];
      s_i_d = sum_i[W:1];
      d_r_d = dif_r[W:1];
      d_i_d = dif_i[W:1];
    end else begin
      s1_ovf = (sum_r[W] ^ sum_r[W-1]) | (sum_i[W] ^ sum_i[W-1]) |
               (dif_r[W] ^ dif_r[W-1]) | (dif_i[W] ^ dif_i[W-1]);
    end
  end

  // Only transactions that really move into the next stage may raise the flag.
  assign ovf_d = ovf_q | (in_valid & adv & s1_ovf) | (v2_q & adv & cm_ovf);

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_r_q  <= s_r_d;
      s1_i_q  <= s_i_d;
      d1_r_q  <= d_r_d;
      d1_i_q  <= d_i_d;
      tw1_r_q <= tw_r;
      tw1_i_q <= tw_i;
      s2_r_q  <= s1_r_q;
      s2_i_q  <= s1_i_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      a_r_q <= '0;
      a_i_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (adv) begin
        v1_q  <= in_valid;
        v2_q  <= v1_q;
        v3_q  <= v2_q;
        a_r_q <= s2_r_q;
        a_i_q <= s2_i_q;
      end
      ovf_q <= ovf_d;
    end
  end

  cmult_conj_pipe #(
    .W    (W),
    .FRAC (FRAC)
  ) u_cmult (
    .clk   (clk),
    .rst   (rst),
    .en_i  (adv),
    .x_r_i (d1_r_q),
    .x_i_i (d1_i_q),
    .w_r_i (tw1_r_q),
    .w_i_i (tw1_i_q),
    .y_r_o (b_r_out),
    .y_i_o (b_i_out),
    .ovf_o (cm_ovf)
  );

  assign out_valid = v3_q;
  assign a_r_out   = a_r_q;
  assign a_i_out   = a_i_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_ibfu_pipe.sv
// Scoreboard bench for ibfu_pipe: one unscaled and one scaled instance share
// stimulus; a reference model fills per-instance queues checked at output transfers.
module tb_ibfu_pipe;
  import bfu_pkg::*;

  localparam int W = W_DEF;

  typedef struct packed {
    cplx_t a;
    cplx_t b;
  } res_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a_r = '0, a_i = '0, b_r = '0, b_i = '0, tw_r = '0, tw_i = '0;

  logic         in_ready0, out_valid0, ovf0;
  logic [W-1:0] a_r_o0, a_i_o0, b_r_o0, b_i_o0;
  logic         in_ready1, out_valid1, ovf1;
  logic [W-1:0] a_r_o1, a_i_o1, b_r_o1, b_i_o1;

  int   checks   = 0;
  int   failures = 0;
  res_t exp0[$];
  res_t exp1[$];
  res_t mon_e0, mon_e1;

  always #5 clk = ~clk;

  ibfu_pipe #(.W(W), .FRAC(FRAC_DEF), .SCALE(0)) u_s0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a_r_in(a_r), .a_i_in(a_i), .b_r_in(b_r), .b_i_in(b_i), .tw_r(tw_r), .tw_i(tw_i),
    .out_valid(out_valid0), .out_ready(out_ready),
    .a_r_out(a_r_o0), .a_i_out(a_i_o0), .b_r_out(b_r_o0), .b_i_out(b_i_o0), .ovf(ovf0)
  );

  ibfu_pipe #(.W(W), .FRAC(FRAC_DEF), .SCALE(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a_r_in(a_r), .a_i_in(a_i), .b_r_in(b_r), .b_i_in(b_i), .tw_r(tw_r), .tw_i(tw_i),
    .out_valid(out_valid1), .out_ready(out_ready),
    .a_r_out(a_r_o1), .a_i_out(a_i_o1), .b_r_out(b_r_o1), .b_i_out(b_i_o1), .ovf(ovf1)
  );

  function automatic res_t model(input logic [31:0] ar, ai, br, bi, twr, twi, input bit scale);
    longint             sr, si, dr, di;
    logic [31:0]        d_r32, d_i32;
    logic signed [64:0] xdr, xdi, xtr, xti, yr, yi;
    res_t               r;
    sr = longint'($signed(ar)) + longint'($signed(br));
    si = longint'($signed(ai)) + longint'($signed(bi));
    dr = longint'($signed(ar)) - longint'($signed(br));
    di = longint'($signed(ai)) - longint'($signed(bi));
    if (scale) begin
      sr = sr >>> 1;
      si = si >>> 1;
      dr = dr >>> 1;
      di = di >>> 1;
    end
    d_r32 = dr[31:0];
    d_i32 = di[31:0];
    xdr = $signed(d_r32);
    xdi = $signed(d_i32);
    xtr = $signed(twr);
    xti = $signed(twi);
    yr = (xdr * xtr + xdi * xti) >>> FRAC_DEF;
    yi = (xdi * xtr - xdr * xti) >>> FRAC_DEF;
    r.a.re = sr[31:0];
    r.a.im = si[31:0];
    r.b.re = yr[31:0];
    r.b.im = yi[31:0];
    return r;
  endfunction

  // Output monitor: every output transfer pops and compares one expected result.
  always @(negedge clk) begin
    if (!rst && out_valid0 && out_ready) begin
      checks++;
      if (exp0.size() == 0) begin
        failures++;
        $display("FAIL s0_unexpected_output got=%h_%h_%h_%h", a_r_o0, a_i_o0, b_r_o0, b_i_o0);
      end else begin
        mon_e0 = exp0.pop_front();
        if ({a_r_o0, a_i_o0, b_r_o0, b_i_o0} !== mon_e0) begin
          failures++;
          $display("FAIL s0_result got=%h_%h_%h_%h exp=%h", a_r_o0, a_i_o0, b_r_o0, b_i_o0, mon_e0);
        end
      end
    end
    if (!rst && out_valid1 && out_ready) begin
      checks++;
      if (exp1.size() == 0) begin
        failures++;
        $display("FAIL s1_unexpected_output got=%h_%h_%h_%h", a_r_o1, a_i_o1, b_r_o1, b_i_o1);
      end else begin
        mon_e1 = exp1.pop_front();
        if ({a_r_o1, a_i_o1, b_r_o1, b_i_o1} !== mon_e1) begin
          failures++;
          $display("FAIL s1_result got=%h_%h_%h_%h exp=%h", a_r_o1, a_i_o1, b_r_o1, b_i_o1, mon_e1);
        end
      end
    end
  end

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    exp0.delete();
    exp1.delete();
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Presents one operand set and returns 1 time unit after its transfer edge.
  task automatic send(input logic [31:0] ar, ai, br, bi, twr, twi);
    int guard;
    a_r = ar; a_i = ai; b_r = br; b_i = bi; tw_r = twr; tw_i = twi;
    in_valid = 1'b1;
    guard = 0;
    forever begin
      @(negedge clk);
      if (in_ready0) begin
        exp0.push_back(model(ar, ai, br, bi, twr, twi, 1'b0));
        exp1.push_back(model(ar, ai, br, bi, twr, twi, 1'b1));
        @(posedge clk);
        #1;
        break;
      end
      guard++;
      if (guard > 50) begin
        checks++;
        failures++;
        $display("FAIL send_timeout in_ready stuck at %b", in_ready0);
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Counts cycles from the transfer cycle (0) to the first cycle out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid0) break;
    end
  endtask

  task automatic test_reset;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    do_reset(2);
    @(negedge clk);
    checks++;
    if ({in_ready0, in_ready1} !== 2'b11) begin
      failures++;
      $display("FAIL reset_in_ready got=%b%b exp=11", in_ready0, in_ready1);
    end
    checks++;
    if ({out_valid0, out_valid1, ovf0, ovf1} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b%b%b%b exp=0000", out_valid0, out_valid1, ovf0, ovf1);
    end
    checks++;
    if ({a_r_o0, a_i_o0, b_r_o0, b_i_o0} !== '0) begin
      failures++;
      $display("FAIL reset_s0_data got=%h_%h_%h_%h exp=0", a_r_o0, a_i_o0, b_r_o0, b_i_o0);
    end
    checks++;
    if ({a_r_o1, a_i_o1, b_r_o1, b_i_o1} !== '0) begin
      failures++;
      $display("FAIL reset_s1_data got=%h_%h_%h_%h exp=0", a_r_o1, a_i_o1, b_r_o1, b_i_o1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_identity;
    int lat;
    send(ONE, 32'h0, ONE, 32'h0, ONE, 32'h0);
    in_valid = 1'b0;
    wait_out(lat);
    checks++;
    if (lat != 3 || out_valid1 !== 1'b1) begin
      failures++;
      $display("FAIL identity_latency got=%0d (s1 valid %b) exp=3", lat, out_valid1);
    end
    checks++;
    if ({a_r_o0, a_i_o0, b_r_o0, b_i_o0} !== {32'h00020000, 32'h0, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL identity_s0 got=%h_%h_%h_%h exp=00020000_0_0_0", a_r_o0, a_i_o0, b_r_o0, b_i_o0);
    end
    checks++;
    if ({ovf0, ovf1} !== 2'b00) begin
      failures++;
      $display("FAIL identity_ovf got=%b%b exp=00", ovf0, ovf1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_conj;
    int lat;
    send(32'h0, 32'h0, ONE, 32'h0, 32'h0, 32'hFFFF0000);
    in_valid = 1'b0;
    wait_out(lat);
    checks++;
    if ({a_r_o0, a_i_o0, b_r_o0, b_i_o0} !== {ONE, 32'h0, 32'h0, 32'hFFFF0000}) begin
      failures++;
      $display("FAIL conj_s0 got=%h_%h_%h_%h exp=00010000_0_0_ffff0000", a_r_o0, a_i_o0, b_r_o0, b_i_o0);
    end
    checks++;
    if ({a_r_o1, a_i_o1, b_r_o1, b_i_o1} !== {32'h00008000, 32'h0, 32'h0, 32'hFFFF8000}) begin
      failures++;
      $display("FAIL conj_s1 got=%h_%h_%h_%h exp=00008000_0_0_ffff8000", a_r_o1, a_i_o1, b_r_o1, b_i_o1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_trunc;
    int lat;
    send(32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h00008000, 32'h0);
    in_valid = 1'b0;
    wait_out(lat);
    checks++;
    if ({b_r_o0, b_i_o0} !== {32'hFFFFFFFF, 32'h0}) begin
      failures++;
      $display("FAIL trunc_s0 got=%h_%h exp=ffffffff_0", b_r_o0, b_i_o0);
    end
    checks++;
    if ({b_r_o1, b_i_o1} !== {32'hFFFFFFFF, 32'h0}) begin
      failures++;
      $display("FAIL trunc_s1 got=%h_%h exp=ffffffff_0", b_r_o1, b_i_o1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_overflow;
    checks++;
    if (ovf0 !== 1'b0) begin
      failures++;
      $display("FAIL ovf_precondition got=%b exp=0", ovf0);
    end
    send(32'h7FFFFFFF, 32'h0, 32'h00000001, 32'h0, ONE, 32'h0);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({ovf0, ovf1} !== 2'b10) begin
      failures++;
      $display("FAIL ovf_set got=%b%b exp=10", ovf0, ovf1);
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ovf0, ovf1} !== 2'b10) begin
      failures++;
      $display("FAIL ovf_sticky got=%b%b exp=10", ovf0, ovf1);
    end
    @(posedge clk);
    #1;
    do_reset(1);
    @(negedge clk);
    checks++;
    if (ovf0 !== 1'b0) begin
      failures++;
      $display("FAIL ovf_cleared got=%b exp=0", ovf0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure;
    logic [127:0] snap;
    int           got, gaps, g;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(32'($urandom_range(0, 2097152)) - 32'd1048576,
               32'($urandom_range(0, 2097152)) - 32'd1048576,
               32'($urandom_range(0, 2097152)) - 32'd1048576,
               32'($urandom_range(0, 2097152)) - 32'd1048576,
               32'($urandom_range(0, 131072)) - ONE,
               32'($urandom_range(0, 131072)) - ONE);
        end
        in_valid = 1'b0;
      end
      begin
        got = 0;
        gaps = 0;
        g = 0;
        do begin
          @(negedge clk);
          g++;
        end while (!out_valid0 && g < 50);
        checks++;
        if (!out_valid0) begin
          failures++;
          $display("FAIL bp_first_valid got=%b exp=1", out_valid0);
        end
        got = 1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          checks++;
          if ({in_ready0, out_valid0} !== 2'b01) begin
            failures++;
            $display("FAIL bp_stall_handshake cycle=%0d got in_ready=%b out_valid=%b exp 0/1", k, in_ready0, out_valid0);
          end
          if (k == 0) begin
            snap = {a_r_o0, a_i_o0, b_r_o0, b_i_o0};
          end else begin
            checks++;
            if ({a_r_o0, a_i_o0, b_r_o0, b_i_o0} !== snap) begin
              failures++;
              $display("FAIL bp_hold cycle=%0d got=%h_%h_%h_%h exp=%h", k, a_r_o0, a_i_o0, b_r_o0, b_i_o0, snap);
            end
          end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        g = 0;
        while (got < 8 && g < 100) begin
          @(negedge clk);
          g++;
          if (out_valid0) got++;
          else gaps++;
        end
        checks++;
        if (got != 8 || gaps != 0) begin
          failures++;
          $display("FAIL bp_throughput got delivered=%0d gaps=%0d exp 8/0", got, gaps);
        end
      end
    join
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      failures++;
      $display("FAIL bp_drain got pending=%0d/%0d exp 0/0", exp0.size(), exp1.size());
    end
  endtask

  task automatic test_reset_midflight;
    int lat, stale;
    out_ready = 1'b0;
    send(32'h7FFFFFFF, 32'h0, 32'h00000001, 32'h0, ONE, 32'h0);
    send(ONE, ONE, 32'h0, 32'h0, ONE, 32'h0);
    send(32'h00030000, 32'h0, ONE, 32'h0, 32'h0, ONE);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid0, ovf0, in_ready0} !== 3'b110) begin
      failures++;
      $display("FAIL midflight_pre got valid=%b ovf=%b in_ready=%b exp 1/1/0", out_valid0, ovf0, in_ready0);
    end
    do_reset(1);
    @(negedge clk);
    checks++;
    if ({out_valid0, out_valid1, ovf0, ovf1} !== 4'b0000) begin
      failures++;
      $display("FAIL midflight_flush got=%b%b%b%b exp=0000", out_valid0, out_valid1, ovf0, ovf1);
    end
    out_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid0 || out_valid1) stale++;
    end
    checks++;
    if (stale != 0) begin
      failures++;
      $display("FAIL midflight_stale got=%0d exp=0", stale);
    end
    @(posedge clk);
    #1;
    send(ONE, 32'h0, 32'h0, 32'h0, ONE, 32'h0);
    in_valid = 1'b0;
    wait_out(lat);
    checks++;
    if (lat != 3 || {a_r_o0, b_r_o0} !== {ONE, ONE}) begin
      failures++;
      $display("FAIL midflight_after got lat=%0d A=%h B=%h exp 3/%h/%h", lat, a_r_o0, b_r_o0, ONE, ONE);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_identity();
    test_conj();
    test_trunc();
    test_overflow();
    test_backpressure();
    test_reset_midflight();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      failures++;
      $display("FAIL final_drain got pending=%0d/%0d exp 0/0", exp0.size(), exp1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
